// File: rtl/txtbuf_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : txtbuf_arbiter
//  Purpose  : Arbiter/sequencer for the single-port 40x24 text page RAM.
//             Shares one RAM access per cycle between the video fetch port,
//             a CPU read/write port and a clear engine that fills the page
//             with the blank character. Grant priority: video > clear > CPU.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50              system clock
//    reset                 asynchronous, active-high
//    vid_req/vid_adr       video fetch strobe and bus address
//    vid_ack/vid_data      fetch completion pulse and byte (3-edge latency)
//    cpu_req/we/adr/wdata  CPU request, held until cpu_ack
//    cpu_ack/rdata/err     CPU completion pulse, read data, range error
//    clr_start/clr_busy    clear engine start pulse and busy flag
//    mem_adr/we/wdata      registered RAM index, write enable, write data
//    mem_rdata             RAM read data, valid one cycle after mem_adr
// ============================================================================
module txtbuf_arbiter #(
  parameter logic [15:0] BASE  = 16'h400,
  parameter int          DEPTH = 1016,
  parameter logic [7:0]  FILL  = 8'hA0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [15:0] vid_adr,
  output logic        vid_ack,
  output logic [7:0]  vid_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_adr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_err,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic [9:0]  mem_adr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [15:0] c_DEPTH = 16'(DEPTH);
  localparam logic [9:0]  c_LAST  = 10'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } cpu_state_t;

  cpu_state_t  cpu_state_q, cpu_state_d;
  logic        cpu_we_q, cpu_we_d;
  logic        cpu_err_q, cpu_err_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;

  // Video pipeline: stage 1 = RAM address issued, stage 2 = RAM data valid.
  logic        vid_v1_q, vid_v1_d, vid_v2_q, vid_v2_d;
  logic        vid_in1_q, vid_in1_d, vid_in2_q, vid_in2_d;
  logic        vid_ack_q, vid_ack_d;
  logic [7:0]  vid_data_q, vid_data_d;

  logic        clr_busy_q, clr_busy_d;
  logic [9:0]  clr_cnt_q, clr_cnt_d;

  logic [9:0]  mem_adr_q, mem_adr_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  logic [15:0] w_vid_off, w_cpu_off;
  logic        w_vid_inr, w_cpu_inr, w_cpu_accept;

  assign w_vid_off = vid_adr - BASE;
  assign w_cpu_off = cpu_adr - BASE;
  assign w_vid_inr = (vid_adr >= BASE) && (w_vid_off < c_DEPTH);
  assign w_cpu_inr = (cpu_adr >= BASE) && (w_cpu_off < c_DEPTH);

  // The CPU only gets a slot in a cycle that neither video nor clear wants.
  assign w_cpu_accept = (cpu_state_q == S_IDLE) && cpu_req && !vid_req && !clr_busy_q;

  always_comb begin
    cpu_state_d = cpu_state_q;
    cpu_we_d    = cpu_we_q;
    cpu_err_d   = cpu_err_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_v1_d    = vid_req;
    vid_in1_d   = vid_req && w_vid_inr;
    vid_v2_d    = vid_v1_q;
    vid_in2_d   = vid_in1_q;
    vid_ack_d   = vid_v2_q;
    vid_data_d  = vid_data_q;
    clr_busy_d  = clr_busy_q;
    clr_cnt_d   = clr_cnt_q;
    mem_adr_d   = mem_adr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    // Out-of-range video fetches still travel the pipeline so latency is fixed.
    if (vid_v2_q) begin
      vid_data_d = vid_in2_q ? mem_rdata : FILL;
    end

    // RAM slot: any video request takes the cycle, even an unmapped one.
    if (vid_req) begin
      if (w_vid_inr) begin
        mem_adr_d = w_vid_off[9:0];
      end
    end else if (clr_busy_q && !clr_start) begin
      mem_adr_d   = clr_cnt_q;
      mem_we_d    = 1'b1;
      mem_wdata_d = FILL;
    end else if (w_cpu_accept && w_cpu_inr) begin
      mem_adr_d = w_cpu_off[9:0];
      mem_we_d  = cpu_we;
      if (cpu_we) begin
        mem_wdata_d = cpu_wdata;
      end
    end

    // Clear engine; a restart pulse discards the current position.
    if (clr_start) begin
      clr_busy_d = 1'b1;
      clr_cnt_d  = '0;
    end else if (clr_busy_q && !vid_req) begin
      if (clr_cnt_q == c_LAST) begin
        clr_busy_d = 1'b0;
        clr_cnt_d  = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 10'd1;
      end
    end

    case (cpu_state_q)
      S_IDLE: begin
        if (w_cpu_accept) begin
          cpu_state_d = S_ISSUE;
          cpu_we_d    = cpu_we;
          cpu_err_d   = !w_cpu_inr;
        end
      end
      S_ISSUE: cpu_state_d = S_WAIT;
      S_WAIT: begin
        cpu_state_d = S_ACK;
        cpu_rdata_d = (!cpu_we_q && !cpu_err_q) ? mem_rdata : 8'h00;
      end
      S_ACK:   cpu_state_d = S_IDLE;
      default: cpu_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cpu_state_q <= S_IDLE;
      cpu_we_q    <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      vid_v1_q    <= 1'b0;
      vid_v2_q    <= 1'b0;
      vid_in1_q   <= 1'b0;
      vid_in2_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      vid_data_q  <= 8'h00;
      clr_busy_q  <= 1'b0;
      clr_cnt_q   <= '0;
      mem_adr_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
    end else begin
      cpu_state_q <= cpu_state_d;
      cpu_we_q    <= cpu_we_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_v1_q    <= vid_v1_d;
      vid_v2_q    <= vid_v2_d;
      vid_in1_q   <= vid_in1_d;
      vid_in2_q   <= vid_in2_d;
      vid_ack_q   <= vid_ack_d;
      vid_data_q  <= vid_data_d;
      clr_busy_q  <= clr_busy_d;
      clr_cnt_q   <= clr_cnt_d;
      mem_adr_q   <= mem_adr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign vid_ack   = vid_ack_q;
  assign vid_data  = vid_data_q;
  assign cpu_ack   = (cpu_state_q == S_ACK);
  assign cpu_err   = cpu_ack && cpu_err_q;
  assign cpu_rdata = cpu_ack ? cpu_rdata_q : 8'h00;
  assign clr_busy  = clr_busy_q;
  assign mem_adr   = mem_adr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_txtbuf_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_txtbuf_arbiter
//  Purpose  : Directed self-checking bench for txtbuf_arbiter with a
//             synchronous RAM model attached to the mem_* port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_txtbuf_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        vid_req, cpu_req, cpu_we, clr_start;
  logic [15:0] vid_adr, cpu_adr;
  logic [7:0]  cpu_wdata, mem_rdata;
  logic        vid_ack, cpu_ack, cpu_err, clr_busy, mem_we;
  logic [7:0]  vid_data, cpu_rdata, mem_wdata;
  logic [9:0]  mem_adr;

  int n_pass  = 0;
  int n_total = 0;

  txtbuf_arbiter dut (
    .CLOCK_50 (CLOCK_50), .reset (reset),
    .vid_req (vid_req), .vid_adr (vid_adr), .vid_ack (vid_ack), .vid_data (vid_data),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_adr (cpu_adr), .cpu_wdata (cpu_wdata),
    .cpu_ack (cpu_ack), .cpu_rdata (cpu_rdata), .cpu_err (cpu_err),
    .clr_start (clr_start), .clr_busy (clr_busy),
    .mem_adr (mem_adr), .mem_we (mem_we), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous single-port RAM, read data one cycle after address.
  logic [7:0] ram [0:1023];
  always @(posedge CLOCK_50) begin
    if (mem_we) ram[mem_adr] <= mem_wdata;
    mem_rdata <= ram[mem_adr];
  end

  // Write/busy log sampled on the falling edge.
  int         we_cnt   = 0;
  int         busy_cnt = 0;
  logic [9:0] idx_log [0:4095];
  logic [7:0] dat_log [0:4095];
  always @(negedge CLOCK_50) begin
    if (mem_we) begin
      idx_log[we_cnt[11:0]] <= mem_adr;
      dat_log[we_cnt[11:0]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (clr_busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] adr, input logic [7:0] wd,
                            output int lat, output logic [7:0] rd, output logic err);
    cpu_we = we; cpu_adr = adr; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0; rd = 8'h00; err = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      tick;
      if (cpu_ack) begin
        lat = n; rd = cpu_rdata; err = cpu_err;
        break;
      end
    end
    cpu_req = 1'b0;
    tick;
  endtask

  task automatic vid_read(input logic [15:0] adr, output int lat, output logic [7:0] d);
    vid_adr = adr; vid_req = 1'b1;
    tick;
    vid_req = 1'b0;
    lat = 1;
    while (!vid_ack && lat < 10) begin
      tick;
      lat++;
    end
    d = vid_ack ? vid_data : 8'h00;
    if (!vid_ack) lat = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1; vid_req = 0; vid_adr = 0; cpu_req = 0; cpu_we = 0; cpu_adr = 0;
    cpu_wdata = 0; clr_start = 0;
    repeat (3) tick;
    n_total++;
    if ({vid_ack, vid_data, cpu_ack, cpu_rdata, cpu_err} !== 19'h0)
      $display("FAIL reset_outs: got %0h expected 0", {vid_ack, vid_data, cpu_ack, cpu_rdata, cpu_err});
    else n_pass++;
    n_total++;
    if ({clr_busy, mem_adr, mem_we, mem_wdata} !== 20'h0)
      $display("FAIL reset_mem: got %0h expected 0", {clr_busy, mem_adr, mem_we, mem_wdata});
    else n_pass++;
    reset = 1'b0;
    repeat (2) tick;
    n_total++;
    if ({clr_busy, mem_we, cpu_ack, vid_ack} !== 4'h0)
      $display("FAIL post_reset_idle: got %0h expected 0", {clr_busy, mem_we, cpu_ack, vid_ack});
    else n_pass++;
  endtask

  task automatic test_clear;
    int c0, b0, n, bad, lat;
    logic [7:0] d;
    c0 = we_cnt; b0 = busy_cnt; bad = 0;
    clr_start = 1'b1; tick; clr_start = 1'b0;
    n = 0;
    while (clr_busy && n < 3000) begin tick; n++; end
    n_total++;
    if (clr_busy !== 1'b0) $display("FAIL clear_done: clr_busy got %0b expected 0", clr_busy);
    else n_pass++;
    repeat (2) tick;
    n_total++;
    if (we_cnt - c0 !== 1016) $display("FAIL clear_writes: got %0d expected 1016", we_cnt - c0);
    else n_pass++;
    n_total++;
    if (busy_cnt - b0 !== 1016) $display("FAIL clear_busy_len: got %0d expected 1016", busy_cnt - b0);
    else n_pass++;
    for (int k = 0; k < 1016; k++)
      if (idx_log[(c0 + k) % 4096] !== 10'(k) || dat_log[(c0 + k) % 4096] !== 8'hA0) bad++;
    n_total++;
    if (bad !== 0) $display("FAIL clear_sequence: got %0d bad writes expected 0", bad);
    else n_pass++;
    vid_read(16'h07F7, lat, d);
    n_total++;
    if (lat !== 3 || d !== 8'hA0) $display("FAIL clear_vid_7F7: got lat %0d data %0h expected lat 3 data a0", lat, d);
    else n_pass++;
  endtask

  task automatic test_cpu_rw;
    int lat;
    logic [7:0] rd;
    logic err;
    cpu_access(1'b1, 16'h040F, 8'h48, lat, rd, err);
    n_total++;
    if (lat !== 3 || err !== 1'b0 || rd !== 8'h00)
      $display("FAIL cpu_write: got lat %0d err %0b rdata %0h expected 3 0 00", lat, err, rd);
    else n_pass++;
    // Read, checking the RAM index while the access is in flight.
    cpu_we = 1'b0; cpu_adr = 16'h040F; cpu_req = 1'b1;
    tick;
    n_total++;
    if (mem_adr !== 10'd15 || mem_we !== 1'b0)
      $display("FAIL cpu_read_adr: got mem_adr %0d we %0b expected 15 0", mem_adr, mem_we);
    else n_pass++;
    tick; tick;
    n_total++;
    if (cpu_ack !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 8'h48)
      $display("FAIL cpu_read: got ack %0b err %0b rdata %0h expected 1 0 48", cpu_ack, cpu_err, cpu_rdata);
    else n_pass++;
    cpu_req = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    int first;
    logic [7:0] rd, exp_d;
    logic exp_ack;
    first = 0; rd = 8'h00;
    vid_adr = 16'h0400; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_adr = 16'h040F; cpu_req = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick;
      exp_ack = (t >= 3 && t <= 22);
      n_total++;
      if (vid_ack !== exp_ack) $display("FAIL b2b_vid_ack t=%0d: got %0b expected %0b", t, vid_ack, exp_ack);
      else n_pass++;
      if (exp_ack) begin
        exp_d = (t - 3 == 15) ? 8'h48 : 8'hA0;
        n_total++;
        if (vid_data !== exp_d) $display("FAIL b2b_vid_data t=%0d: got %0h expected %0h", t, vid_data, exp_d);
        else n_pass++;
      end
      if (cpu_ack && first == 0) begin
        first = t; rd = cpu_rdata; cpu_req = 1'b0;
      end
      if (t < 20) vid_adr = 16'h0400 + 16'(t);
      else vid_req = 1'b0;
    end
    n_total++;
    if (first !== 23 || rd !== 8'h48)
      $display("FAIL b2b_cpu_ack: got tick %0d rdata %0h expected 23 48", first, rd);
    else n_pass++;
  endtask

  task automatic test_out_of_range;
    int lat, c0;
    logic [7:0] rd;
    logic err;
    c0 = we_cnt;
    cpu_access(1'b0, 16'h03FF, 8'h00, lat, rd, err);
    n_total++;
    if (lat !== 3 || err !== 1'b1 || rd !== 8'h00)
      $display("FAIL oor_cpu_read: got lat %0d err %0b rdata %0h expected 3 1 00", lat, err, rd);
    else n_pass++;
    cpu_access(1'b1, 16'h07F8, 8'h77, lat, rd, err);
    n_total++;
    if (lat !== 3 || err !== 1'b1 || rd !== 8'h00)
      $display("FAIL oor_cpu_write: got lat %0d err %0b rdata %0h expected 3 1 00", lat, err, rd);
    else n_pass++;
    tick;
    n_total++;
    if (we_cnt !== c0) $display("FAIL oor_no_write: got %0d writes expected 0", we_cnt - c0);
    else n_pass++;
    vid_read(16'h0800, lat, rd);
    n_total++;
    if (lat !== 3 || rd !== 8'hA0) $display("FAIL oor_vid: got lat %0d data %0h expected 3 a0", lat, rd);
    else n_pass++;
  endtask

  task automatic test_clear_restart;
    int c0, t, tail, lat_bad, dat_bad, r, tot, bad;
    logic s0, s1, s2, restarted;
    c0 = we_cnt; t = 0; tail = -1; lat_bad = 0; dat_bad = 0;
    s0 = 0; s1 = 0; s2 = 0; restarted = 0;
    clr_start = 1'b1; tick; clr_start = 1'b0;
    while (t < 8000 && tail != 0) begin
      vid_adr = 16'h07F7;
      vid_req = (tail < 0) && t[0];
      clr_start = !restarted && (we_cnt - c0 >= 501);
      if (clr_start) restarted = 1'b1;
      tick;
      s2 = s1; s1 = s0; s0 = vid_req;
      if (vid_ack !== s2) lat_bad++;
      if (vid_ack && vid_data !== 8'hA0) dat_bad++;
      if (tail > 0) tail--;
      else if (tail < 0 && restarted && !clr_busy) tail = 4;
      t++;
    end
    clr_start = 1'b0; vid_req = 1'b0;
    n_total++;
    if (tail !== 0) $display("FAIL restart_done: got busy %0b expected 0", clr_busy);
    else n_pass++;
    n_total++;
    if (lat_bad !== 0 || dat_bad !== 0)
      $display("FAIL restart_video: got %0d late %0d bad data expected 0 0", lat_bad, dat_bad);
    else n_pass++;
    tot = we_cnt - c0; r = 0; bad = 0;
    for (int j = 1; j < tot; j++)
      if (r == 0 && idx_log[(c0 + j) % 4096] == 10'd0) r = j;
    for (int j = 0; j < r; j++)
      if (idx_log[(c0 + j) % 4096] !== 10'(j)) bad++;
    for (int j = 0; j < 1016; j++)
      if (idx_log[(c0 + r + j) % 4096] !== 10'(j)) bad++;
    n_total++;
    if (r < 501 || r > 503 || bad !== 0)
      $display("FAIL restart_seq: got restart at %0d with %0d bad expected 501..503 and 0", r, bad);
    else n_pass++;
    n_total++;
    if (tot !== r + 1016) $display("FAIL restart_total: got %0d expected %0d", tot, r + 1016);
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    int c0, n, bad, lat;
    logic [7:0] rd;
    logic err;
    c0 = we_cnt;
    clr_start = 1'b1; tick; clr_start = 1'b0;
    n = 0;
    while (we_cnt - c0 < 300 && n < 2000) begin tick; n++; end
    reset = 1'b1;
    #1;
    n_total++;
    if (clr_busy !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL abort_clear: got busy %0b we %0b expected 0 0", clr_busy, mem_we);
    else n_pass++;
    tick; tick;
    reset = 1'b0;
    c0 = we_cnt; bad = 0;
    repeat (10) begin
      tick;
      if (clr_busy || cpu_ack || mem_we) bad++;
    end
    n_total++;
    if (bad !== 0 || we_cnt !== c0)
      $display("FAIL abort_clear_quiet: got %0d active cycles %0d writes expected 0 0", bad, we_cnt - c0);
    else n_pass++;
    // Abort a CPU write while it is in ISSUE.
    cpu_we = 1'b1; cpu_adr = 16'h0410; cpu_wdata = 8'h55; cpu_req = 1'b1;
    tick;
    n_total++;
    if (mem_we !== 1'b1 || mem_adr !== 10'd16)
      $display("FAIL abort_cpu_issue: got we %0b adr %0d expected 1 16", mem_we, mem_adr);
    else n_pass++;
    reset = 1'b1;
    #1;
    c0 = we_cnt; cpu_req = 1'b0; bad = 0;
    tick; tick;
    reset = 1'b0;
    repeat (6) begin
      tick;
      if (cpu_ack || clr_busy) bad++;
    end
    n_total++;
    if (bad !== 0 || we_cnt !== c0 || ram[16] !== 8'hA0)
      $display("FAIL abort_cpu: got %0d acks %0d writes ram %0h expected 0 0 a0", bad, we_cnt - c0, ram[16]);
    else n_pass++;
    cpu_access(1'b0, 16'h0410, 8'h00, lat, rd, err);
    n_total++;
    if (lat !== 3 || err !== 1'b0 || rd !== 8'hA0)
      $display("FAIL after_abort_read: got lat %0d err %0b rdata %0h expected 3 0 a0", lat, err, rd);
    else n_pass++;
    cpu_access(1'b1, 16'h0410, 8'h55, lat, rd, err);
    cpu_access(1'b0, 16'h0410, 8'h00, lat, rd, err);
    n_total++;
    if (lat !== 3 || err !== 1'b0 || rd !== 8'h55)
      $display("FAIL after_abort_rw: got lat %0d err %0b rdata %0h expected 3 0 55", lat, err, rd);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_clear;
    test_cpu_rw;
    test_back_to_back;
    test_out_of_range;
    test_clear_restart;
    test_reset_abort;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
